// File: rtl/count_year_bcd_if.sv
// Control and status bundle between the clock UI / month counter and the BCD year counter.
interface count_year_bcd_if #(
    parameter int unsigned NDIG = 4
);
    localparam int unsigned W = 4 * NDIG;

    logic         en_yr;
    logic         up;
    logic         down;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] year_bcd;
    logic         leap_year;
    logic         wrap_up;
    logic         wrap_dn;
    logic         load_err;

    modport master (
        output en_yr, up, down, load, load_val,
        input  year_bcd, leap_year, wrap_up, wrap_dn, load_err
    );

    modport slave (
        input  en_yr, up, down, load, load_val,
        output year_bcd, leap_year, wrap_up, wrap_dn, load_err
    );
endinterface

// File: rtl/count_year_bcd.sv
// N-digit packed-BCD year counter with programmable wrap range, checked parallel load
// and Gregorian leap-year decode of the low four digits.
module count_year_bcd #(
    parameter int unsigned         NDIG    = 4,
    parameter logic [4*NDIG-1:0]   RST_VAL = (4*NDIG)'(16'h2000),
    parameter logic [4*NDIG-1:0]   MIN_VAL = (4*NDIG)'(16'h0000),
    parameter logic [4*NDIG-1:0]   MAX_VAL = (4*NDIG)'(16'h9999)
) (
    input logic             clk,
    input logic             rst,
    count_year_bcd_if.slave bus
);
    localparam int unsigned W = 4 * NDIG;

    logic [W-1:0] year_q, year_d;
    logic         wrap_up_q, wrap_up_d;
    logic         wrap_dn_q, wrap_dn_d;
    logic         load_err_q, load_err_d;

    logic [W:0]   lo_diff_c;
    logic [W:0]   hi_diff_c;
    logic         load_ok_c;

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int unsigned k = 0; k < NDIG; k++) begin
            if (carry) begin
                if (v[4*k +: 4] == 4'd9) begin
                    r[4*k +: 4] = 4'd0;
                end else begin
                    r[4*k +: 4] = v[4*k +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int unsigned k = 0; k < NDIG; k++) begin
            if (borrow) begin
                if (v[4*k +: 4] == 4'd0) begin
                    r[4*k +: 4] = 4'd9;
                end else begin
                    r[4*k +: 4] = v[4*k +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic bcd_valid(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int unsigned k = 0; k < NDIG; k++) begin
            if (v[4*k +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // Two-digit BCD divisibility by 4: tens parity selects which units digits qualify.
    function automatic logic div4(input logic [3:0] d1, input logic [3:0] d0);
        logic even_ok;
        logic odd_ok;
        even_ok = (d0 == 4'd0) || (d0 == 4'd4) || (d0 == 4'd8);
        odd_ok  = (d0 == 4'd2) || (d0 == 4'd6);
        return d1[0] ? odd_ok : even_ok;
    endfunction

    // Range check by subtraction; the borrow bit flags an out-of-range value.
    assign lo_diff_c = {1'b0, bus.load_val} - {1'b0, MIN_VAL};
    assign hi_diff_c = {1'b0, MAX_VAL} - {1'b0, bus.load_val};
    assign load_ok_c = bcd_valid(bus.load_val) && !lo_diff_c[W] && !hi_diff_c[W];

    always_comb begin
        year_d     = year_q;
        wrap_up_d  = 1'b0;
        wrap_dn_d  = 1'b0;
        load_err_d = 1'b0;
        if (bus.load) begin
            if (load_ok_c) begin
                year_d = bus.load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (bus.en_yr || (bus.up && !bus.down)) begin
            if (year_q == MAX_VAL) begin
                year_d    = MIN_VAL;
                wrap_up_d = 1'b1;
            end else begin
                year_d = bcd_inc(year_q);
            end
        end else if (bus.down && !bus.up) begin
            if (year_q == MIN_VAL) begin
                year_d    = MAX_VAL;
                wrap_dn_d = 1'b1;
            end else begin
                year_d = bcd_dec(year_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            year_q     <= RST_VAL;
            wrap_up_q  <= 1'b0;
            wrap_dn_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            year_q     <= year_d;
            wrap_up_q  <= wrap_up_d;
            wrap_dn_q  <= wrap_dn_d;
            load_err_q <= load_err_d;
        end
    end

    // Non-century years use the last two digits; centuries fall back to digits 3:2.
    assign bus.leap_year = (year_q[7:0] != 8'h00) ? div4(year_q[7:4], year_q[3:0])
                                                  : div4(year_q[15:12], year_q[11:8]);

    assign bus.year_bcd = year_q;
    assign bus.wrap_up  = wrap_up_q;
    assign bus.wrap_dn  = wrap_dn_q;
    assign bus.load_err = load_err_q;
endmodule

// File: tb/tb_count_year_bcd.sv
// Scoreboard bench for count_year_bcd: three instances (default range, narrowed range, six digits).
module tb_count_year_bcd;
    localparam logic [15:0] D0_RST = 16'h2000, D0_MIN = 16'h0000, D0_MAX = 16'h9999;
    localparam logic [15:0] D1_RST = 16'h2000, D1_MIN = 16'h1900, D1_MAX = 16'h2099;
    localparam logic [23:0] D2_RST = 24'h002000, D2_MIN = 24'h000000, D2_MAX = 24'h999999;

    logic clk;
    logic rst;

    count_year_bcd_if #(.NDIG(4)) if0 ();
    count_year_bcd_if #(.NDIG(4)) if1 ();
    count_year_bcd_if #(.NDIG(6)) if2 ();

    count_year_bcd u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    count_year_bcd #(.NDIG(4), .RST_VAL(D1_RST), .MIN_VAL(D1_MIN), .MAX_VAL(D1_MAX))
        u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    count_year_bcd #(.NDIG(6), .RST_VAL(D2_RST), .MIN_VAL(D2_MIN), .MAX_VAL(D2_MAX))
        u_dut2 (.clk(clk), .rst(rst), .bus(if2));

    typedef struct {
        string       tag;
        int          idx;
        logic [31:0] year;
        logic        leap;
        logic        wup;
        logic        wdn;
        logic        lerr;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_year[3];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    function automatic int p_nd(input int idx);
        return (idx == 2) ? 6 : 4;
    endfunction
    function automatic logic [31:0] p_rst(input int idx);
        return (idx == 0) ? 32'(D0_RST) : (idx == 1) ? 32'(D1_RST) : 32'(D2_RST);
    endfunction
    function automatic logic [31:0] p_min(input int idx);
        return (idx == 0) ? 32'(D0_MIN) : (idx == 1) ? 32'(D1_MIN) : 32'(D2_MIN);
    endfunction
    function automatic logic [31:0] p_max(input int idx);
        return (idx == 0) ? 32'(D0_MAX) : (idx == 1) ? 32'(D1_MAX) : 32'(D2_MAX);
    endfunction

    function automatic int unsigned bcd2int(input logic [31:0] v, input int nd);
        int unsigned n = 0;
        for (int k = nd - 1; k >= 0; k--) n = n * 10 + 32'(v[4*k +: 4]);
        return n;
    endfunction

    function automatic logic [31:0] int2bcd(input int unsigned n, input int nd);
        logic [31:0] r = '0;
        for (int k = 0; k < nd; k++) begin
            r[4*k +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction

    function automatic bit nib_ok(input logic [31:0] v, input int nd);
        for (int k = 0; k < nd; k++) if (v[4*k +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic leap_of(input logic [31:0] v);
        int unsigned y = bcd2int(v, 4);
        return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_in(input int idx, input bit en, input bit u, input bit d,
                          input bit ld, input logic [31:0] val);
        case (idx)
            0: begin if0.en_yr = en; if0.up = u; if0.down = d; if0.load = ld; if0.load_val = val[15:0]; end
            1: begin if1.en_yr = en; if1.up = u; if1.down = d; if1.load = ld; if1.load_val = val[15:0]; end
            default: begin if2.en_yr = en; if2.up = u; if2.down = d; if2.load = ld; if2.load_val = val[23:0]; end
        endcase
    endtask

    task automatic get_out(input int idx, output logic [31:0] y, output logic lp,
                           output logic wu, output logic wd, output logic le);
        case (idx)
            0: begin y = 32'(if0.year_bcd); lp = if0.leap_year; wu = if0.wrap_up; wd = if0.wrap_dn; le = if0.load_err; end
            1: begin y = 32'(if1.year_bcd); lp = if1.leap_year; wu = if1.wrap_up; wd = if1.wrap_dn; le = if1.load_err; end
            default: begin y = 32'(if2.year_bcd); lp = if2.leap_year; wu = if2.wrap_up; wd = if2.wrap_dn; le = if2.load_err; end
        endcase
    endtask

    // Reference behaviour: produce the expected post-edge state and queue it.
    task automatic predict(input int idx, input bit en, input bit u, input bit d,
                           input bit ld, input logic [31:0] val, input string tag);
        exp_t        e;
        logic [31:0] y;
        int          nd = p_nd(idx);
        y = m_year[idx];
        e = '{tag: tag, idx: idx, year: '0, leap: 1'b0, wup: 1'b0, wdn: 1'b0, lerr: 1'b0};
        if (ld) begin
            if (nib_ok(val, nd) && val >= p_min(idx) && val <= p_max(idx)) y = val;
            else e.lerr = 1'b1;
        end else if (en || (u && !d)) begin
            if (y == p_max(idx)) begin y = p_min(idx); e.wup = 1'b1; end
            else y = int2bcd(bcd2int(y, nd) + 1, nd);
        end else if (d && !u) begin
            if (y == p_min(idx)) begin y = p_max(idx); e.wdn = 1'b1; end
            else y = int2bcd(bcd2int(y, nd) - 1, nd);
        end
        m_year[idx] = y;
        e.year      = y;
        e.leap      = leap_of(y);
        sb_q.push_back(e);
    endtask

    task automatic compare_next();
        exp_t        e;
        logic [31:0] y;
        logic        lp, wu, wd, le;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        get_out(e.idx, y, lp, wu, wd, le);
        check({e.tag, ".year"}, y, e.year);
        check({e.tag, ".leap"}, 32'(lp), 32'(e.leap));
        check({e.tag, ".wrap_up"}, 32'(wu), 32'(e.wup));
        check({e.tag, ".wrap_dn"}, 32'(wd), 32'(e.wdn));
        check({e.tag, ".load_err"}, 32'(le), 32'(e.lerr));
    endtask

    task automatic step(input int idx, input bit en, input bit u, input bit d,
                        input bit ld, input logic [31:0] val, input string tag);
        @(negedge clk);
        set_in(idx, en, u, d, ld, val);
        predict(idx, en, u, d, ld, val, tag);
        @(posedge clk);
        #1;
        set_in(idx, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        compare_next();
    endtask

    task automatic reset_models();
        for (int i = 0; i < 3; i++) m_year[i] = p_rst(i);
    endtask

    task automatic check_reset_state(input string tag);
        logic [31:0] y;
        logic        lp, wu, wd, le;
        for (int i = 0; i < 3; i++) begin
            get_out(i, y, lp, wu, wd, le);
            check($sformatf("%s%0d.year", tag, i), y, p_rst(i));
            check($sformatf("%s%0d.leap", tag, i), 32'(lp), 32'(leap_of(p_rst(i))));
            check($sformatf("%s%0d.pulses", tag, i), {29'd0, wu, wd, le}, 32'd0);
        end
    endtask

    initial begin
        assert (D0_RST >= D0_MIN && D0_RST <= D0_MAX) else $error("dut0 RST_VAL outside range");
        assert (D1_RST >= D1_MIN && D1_RST <= D1_MAX) else $error("dut1 RST_VAL outside range");
        assert (D2_RST >= D2_MIN && D2_RST <= D2_MAX) else $error("dut2 RST_VAL outside range");
    end

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) set_in(i, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        reset_models();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("rst_hold");
        @(negedge clk);
        rst = 1'b0;

        // Default range instance: leap rules, priority, load rejection, wrap both ways.
        step(0, 0, 0, 0, 0, 32'h0,    "d0_idle");
        step(0, 0, 0, 0, 1, 32'h1899, "d0_ld1899");
        step(0, 1, 0, 0, 0, 32'h0,    "d0_en1900");
        step(0, 0, 0, 0, 1, 32'h1996, "d0_ld1996");
        step(0, 0, 0, 0, 1, 32'h2023, "d0_ld2023");
        step(0, 0, 0, 0, 1, 32'h2009, "d0_ld2009");
        step(0, 1, 1, 0, 0, 32'h0,    "d0_en_up");
        step(0, 0, 1, 1, 0, 32'h0,    "d0_up_dn");
        step(0, 1, 0, 0, 1, 32'h2150, "d0_ld_en");
        step(0, 0, 0, 0, 1, 32'h20A5, "d0_badnib");
        step(0, 0, 0, 0, 0, 32'h0,    "d0_lerr_clr");
        step(0, 0, 0, 1, 0, 32'h0,    "d0_dn2149");
        step(0, 0, 0, 1, 1, 32'h9999, "d0_ld9999");
        step(0, 0, 1, 0, 0, 32'h0,    "d0_wrap_up");
        step(0, 0, 0, 0, 0, 32'h0,    "d0_wup_clr");
        step(0, 0, 0, 1, 0, 32'h0,    "d0_wrap_dn");
        step(0, 0, 0, 0, 0, 32'h0,    "d0_wdn_clr");
        step(0, 0, 0, 0, 1, 32'h2400, "d0_ld2400");
        step(0, 0, 0, 0, 1, 32'h2100, "d0_ld2100");
        step(0, 0, 0, 0, 1, 32'h0990, "d0_ld0990");
        step(0, 0, 0, 1, 0, 32'h0,    "d0_borrow");

        // Narrowed range instance.
        step(1, 0, 0, 0, 1, 32'h2099, "d1_ld2099");
        step(1, 0, 1, 0, 0, 32'h0,    "d1_wrap_up");
        step(1, 0, 0, 0, 0, 32'h0,    "d1_wup_clr");
        step(1, 0, 0, 1, 0, 32'h0,    "d1_wrap_dn");
        step(1, 0, 0, 0, 0, 32'h0,    "d1_wdn_clr");
        step(1, 0, 0, 0, 1, 32'h2100, "d1_above_max");
        step(1, 0, 0, 0, 1, 32'h1899, "d1_below_min");
        step(1, 1, 0, 1, 0, 32'h0,    "d1_en_wrap");
        step(1, 0, 0, 0, 1, 32'h1900, "d1_ld_min");

        // Six-digit instance: full ripple and low-four-digit leap decode.
        step(2, 0, 0, 0, 1, 32'h099999, "d2_ld099999");
        step(2, 0, 1, 0, 0, 32'h0,      "d2_ripple");
        step(2, 0, 0, 1, 0, 32'h0,      "d2_borrow");
        step(2, 0, 0, 0, 1, 32'h123400, "d2_ld123400");
        step(2, 0, 0, 0, 1, 32'h990096, "d2_ld990096");
        step(2, 0, 0, 0, 1, 32'h0A0000, "d2_badnib");
        step(2, 0, 0, 0, 1, 32'h999999, "d2_ld999999");
        step(2, 0, 1, 0, 0, 32'h0,      "d2_wrap_up");

        // Asynchronous reset mid-count while up is held on instance 0.
        @(negedge clk);
        set_in(0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        predict(0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, "d0_pre_rst");
        @(posedge clk);
        #1;
        compare_next();
        #2;
        rst = 1'b1;
        #1;
        reset_models();
        check_reset_state("rst_async");
        @(negedge clk);
        rst = 1'b0;
        predict(0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, "d0_resume");
        @(posedge clk);
        #1;
        set_in(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        compare_next();

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/count_year_bcd.md
Name: count_year_bcd

Overview:
Parametrised N-digit BCD year counter. It generalises the fixed 4-digit calendar year counter with the following additions:
- configurable digit count
- programmable reset, minimum and maximum values (wrap range)
- parallel load with validity checking
- wrap indication pulses
- full Gregorian leap-year decode, including the 100/400 century rule

It sits in the century clock datapath after the month counter, which drives en_yr on the Dec→Jan rollover. The setting UI drives up/down/load.

Parameters:
NDIG, 4, number of BCD digits; legal range 4..8; digit 0 is the units digit.
RST_VAL, 16'h2000, reset value; packed BCD, width 4*NDIG.
MIN_VAL, 16'h0000, lowest count; packed BCD; MIN_VAL ≤ MAX_VAL.
MAX_VAL, 16'h9999, highest count; packed BCD.

Ports:
clk  input  1  clock; all state changes on its rising edge.
rst  input  1  asynchronous reset, active-high.
en_yr  input  1  carry from month counter; increments the year by 1.
up  input  1  manual increment request; level, sampled every cycle.
down  input  1  manual decrement request; level, sampled every cycle.
load  input  1  parallel-load strobe.
load_val  input  4*NDIG  packed BCD value to load.
year_bcd  output  4*NDIG  current year, packed BCD; digit k at bits [4k+3:4k].
leap_year  output  1  high when year_bcd is a Gregorian leap year.
wrap_up  output  1  one-cycle pulse on increment from MAX_VAL to MIN_VAL.
wrap_dn  output  1  one-cycle pulse on decrement from MIN_VAL to MAX_VAL.
load_err  output  1  one-cycle pulse when a load is rejected.

Behaviour:
Clock and reset:
- Single clock domain.
- rst asserted (at any time, including mid-operation) forces asynchronously: year_bcd=RST_VAL, wrap_up=0, wrap_dn=0, load_err=0.
- leap_year during reset is the decode of RST_VAL.

Per-cycle priority (highest first). Exactly one action per cycle:
1. load=1: accept if every nibble of load_val ≤ 9 and MIN_VAL ≤ load_val ≤ MAX_VAL. Accepted: year_bcd←load_val. Rejected: hold and pulse load_err. en_yr, up and down are ignored that cycle.
2. en_yr=1: increment. up/down are ignored that cycle. No double step when en_yr=1 and up=1.
3. up=1, down=0: increment.
4. down=1, up=0: decrement.
5. Otherwise (including up=down=1): hold.

Increment:
- If year_bcd==MAX_VAL: year_bcd←MIN_VAL and wrap_up=1 next cycle.
- Else BCD +1 with ripple: a digit at 9 becomes 0 and carries into the next digit. The carry never leaves digit NDIG-1.

Decrement:
- If year_bcd==MIN_VAL: year_bcd←MAX_VAL and wrap_dn=1 next cycle.
- Else BCD −1 with borrow: a digit at 0 becomes 9 and borrows from the next digit.

Comparisons and latency:
- Range comparisons are unsigned on packed BCD; this is valid because BCD ordering equals numeric ordering.
- Latency: year_bcd updates on the clock edge after the request is sampled; there are no internal stages.
- wrap_up, wrap_dn and load_err are registered. Each is high for exactly the cycle following the triggering edge, then clears unless re-triggered.

Leap decode:
- leap_year is a combinational decode of the registered year_bcd; it has zero latency relative to year_bcd.
- Let Y = digits 1:0 and C = digits 3:2 (higher digits are ignored).
- div4(d1,d0) = (d1 even AND d0∈{0,4,8}) OR (d1 odd AND d0∈{2,6}).
- leap_year = (Y≠00 AND div4(Y)) OR (Y==00 AND div4(C)).

Holding and hold-off:
- Holding level up/down steps once per clock; any rate limiting is upstream.
- Values outside [MIN_VAL, MAX_VAL] are unreachable after reset. A parameter set with RST_VAL outside the range is illegal; the bench flags it by assertion.

Test Plan:
- Reset, then release with defaults → year_bcd=16'h2000, leap_year=1 (2000 divisible by 400), all pulses 0.
- Load 16'h1899, then en_yr for 1 cycle → 16'h1900, leap_year=0 (century not divisible by 400). Then load 16'h1996 → leap_year=1. Then load 16'h2023 → leap_year=0.
- MIN_VAL=16'h1900, MAX_VAL=16'h2099 at year 16'h2099, one up pulse → 16'h1900 with wrap_up high one cycle. Then one down → 16'h2099 with wrap_dn high one cycle.
- Simultaneous inputs:
  - en_yr=1 with up=1 at 16'h2009 → 16'h2010 (single step).
  - up=down=1 → hold.
  - load=1, load_val=16'h2150, en_yr=1 → 16'h2150.
- Rejected loads:
  - load_val=16'h20A5 (bad nibble) → year_bcd unchanged, load_err pulse.
  - load_val above MAX_VAL → unchanged, load_err pulse.
- rst asserted mid-count, between clock edges, while up is held → year_bcd=RST_VAL immediately; counting resumes on the first edge after rst deasserts.
- NDIG=6 with defaults extended: 16'h…099999 increments ripple correctly through all six digits, and leap_year uses digits 3:0 only.
